morse_player: RTL

- Transmit side of the Morse link. Takes a packed 20-bit Morse code word and plays it out as a timed on/off signal for an LED or buzzer.
- Code format: each dot is appended as 2'b10 and each line as 4'b1110. Packing is right-aligned, so the last symbol sits in the LSBs. Leading zeros are padding.
- Used to present player1's secret code to player2, and to replay player2's attempt.

---
 rtl/morse_pkg.sv | 16 +
 rtl/unit_timer.sv | 27 ++
 rtl/morse_player.sv | 124 ++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared Morse constants and player state encoding, used by both the player and the capture side.
package morse_pkg;

  localparam int unsigned MORSE_CODE_WIDTH = 20;
  localparam logic [1:0]  MORSE_DOT        = 2'b10;
  localparam logic [3:0]  MORSE_LINE       = 4'b1110;

  typedef logic [2:0] player_state_t;

  localparam player_state_t StIdle = 3'd0;
  localparam player_state_t StSeek = 3'd1;
  localparam player_state_t StEmit = 3'd2;
  localparam player_state_t StGap  = 3'd3;
  localparam player_state_t StDone = 3'd4;

endpackage

// File: rtl/unit_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module unit_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/morse_player.sv
// Plays a right-aligned packed Morse word as timed on/off units followed by an inter-letter gap.
module morse_player
  import morse_pkg::*;
#(
  parameter int unsigned CODE_WIDTH = MORSE_CODE_WIDTH,
  parameter int unsigned UNIT_TICKS = 25000000,
  parameter int unsigned GAP_UNITS  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  signal,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned GapTicks = GAP_UNITS * UNIT_TICKS;
  localparam int unsigned TickW    = (GapTicks > 1) ? $clog2(GapTicks) : 1;
  localparam int unsigned CntW     = $clog2(CODE_WIDTH + 1);

  localparam logic [TickW-1:0] UnitLoad = TickW'(UNIT_TICKS - 1);
  localparam logic [TickW-1:0] GapLoad  = TickW'(GapTicks - 1);
  localparam logic [CntW-1:0]  CntInit  = CntW'(CODE_WIDTH);

  player_state_t         state_q, state_d;
  logic [CODE_WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]       bitcnt_q, bitcnt_d;
  logic                  signal_q, signal_d;

  logic             tick_load;
  logic [TickW-1:0] tick_value;
  logic             tick_en;
  logic             tick_zero;

  unit_timer #(
    .Width (TickW)
  ) u_unit_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tick_load),
    .load_value (tick_value),
    .enable     (tick_en),
    .zero       (tick_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      signal_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      signal_q <= signal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    signal_d   = 1'b0;
    tick_load  = 1'b0;
    tick_value = UnitLoad;
    tick_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shreg_d  = code;
          bitcnt_d = CntInit;
          state_d  = StSeek;
        end
      end
      StSeek: begin
        // An all-zero word runs out of bits here and skips the gap entirely.
        if (bitcnt_q == '0) begin
          state_d = StDone;
        end else if (shreg_q[CODE_WIDTH-1]) begin
          tick_load = 1'b1;
          state_d   = StEmit;
        end else begin
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q - CntW'(1);
        end
      end
      StEmit: begin
        signal_d = shreg_q[CODE_WIDTH-1];
        if (tick_zero) begin
          shreg_d   = shreg_q << 1;
          bitcnt_d  = bitcnt_q - CntW'(1);
          tick_load = 1'b1;
          if (bitcnt_q == CntW'(1)) begin
            tick_value = GapLoad;
            state_d    = StGap;
          end
        end else begin
          tick_en = 1'b1;
        end
      end
      StGap: begin
        if (tick_zero) begin
          state_d = StDone;
        end else begin
          tick_en = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign signal = signal_q;
  assign busy   = (state_q != StIdle) && (state_q != StDone);
  assign done   = (state_q == StDone);

endmodule
